// File: rtl/branch_cache_writer.sv
// branch_cache_writer: write side of the branch target cache, with a fetch lookup port
module branch_cache_writer #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3,
    parameter int AW      = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             iUpdValid,
    output logic             oUpdReady,
    input  logic [AW-1:0]    iUpdPC,
    input  logic [AW-1:0]    iUpdTarget,
    input  logic             iUpdKind,
    input  logic [AW-1:0]    iLookupPC,
    output logic [AW-1:0]    oCacheAddress,
    output logic             ocCache,
    output logic             oEvict,
    output logic             oReject,
    output logic [IDX_W:0]   oFillCount
);
    typedef enum logic [1:0] {IDLE, SEARCH, WRITE} state_t;
    state_t               state_q, state_d;
    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [AW-1:0]        pc_arr_q [ENTRIES];
    logic [AW-1:0]        pc_arr_d [ENTRIES];
    logic [AW-1:0]        tgt_arr_q [ENTRIES];
    logic [AW-1:0]        tgt_arr_d [ENTRIES];
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [AW-1:0]        upd_pc_q, upd_pc_d;
    logic [AW-1:0]        upd_tgt_q, upd_tgt_d;
    logic                 upd_kind_q, upd_kind_d;
    logic                 hit_q, hit_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 evict_q, evict_d;
    logic                 reject_q, reject_d;
    logic [IDX_W:0]       fill_q, fill_d;
    logic                 s_hit, s_free;
    logic [IDX_W-1:0]     s_hit_idx, s_free_idx;
    logic                 misaligned;
    assign oUpdReady  = state_q == IDLE;
    assign oEvict     = evict_q;
    assign oReject    = reject_q;
    assign oFillCount = fill_q;
    assign misaligned = (iUpdPC[1:0] != 2'b00) || (iUpdKind && iUpdTarget[1:0] != 2'b00);
    // Fetch lookup: lowest-index valid entry whose PC matches wins
    always_comb begin
        ocCache       = 1'b0;
        oCacheAddress = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && pc_arr_q[i] == iLookupPC) begin
                ocCache       = 1'b1;
                oCacheAddress = tgt_arr_q[i];
            end
        end
    end
    // Search of the latched PC: lowest matching entry and lowest free entry
    always_comb begin
        s_hit      = 1'b0;
        s_hit_idx  = '0;
        s_free     = 1'b0;
        s_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && pc_arr_q[i] == upd_pc_q) begin
                s_hit     = 1'b1;
                s_hit_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                s_free     = 1'b1;
                s_free_idx = IDX_W'(i);
            end
        end
    end
    // Update FSM next state: accept/reject, search, then a single table write
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        pc_arr_d   = pc_arr_q;
        tgt_arr_d  = tgt_arr_q;
        rr_d       = rr_q;
        upd_pc_d   = upd_pc_q;
        upd_tgt_d  = upd_tgt_q;
        upd_kind_d = upd_kind_q;
        hit_d      = hit_q;
        idx_d      = idx_q;
        evict_d    = 1'b0;
        reject_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (iUpdValid) begin
                    reject_d   = misaligned;
                    state_d    = misaligned ? IDLE : SEARCH;
                    upd_pc_d   = misaligned ? upd_pc_q : iUpdPC;
                    upd_tgt_d  = misaligned ? upd_tgt_q : iUpdTarget;
                    upd_kind_d = misaligned ? upd_kind_q : iUpdKind;
                end
            end
            SEARCH: begin
                hit_d   = s_hit;
                idx_d   = s_hit ? s_hit_idx : s_free ? s_free_idx : rr_q;
                state_d = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
                if (upd_kind_q) begin
                    tgt_arr_d[idx_q] = upd_tgt_q;
                    if (!hit_q) begin
                        pc_arr_d[idx_q] = upd_pc_q;
                        valid_d[idx_q]  = 1'b1;
                        evict_d         = &valid_q;
                        rr_d            = &valid_q ? rr_q + IDX_W'(1) : rr_q;
                    end
                end else if (hit_q) begin
                    valid_d[idx_q] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        fill_d = '0;
        for (int i = 0; i < ENTRIES; i++) fill_d = fill_d + (IDX_W+1)'(valid_d[i]);
    end
    // State and table registers, cleared asynchronously so an in-flight update is dropped
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            pc_arr_q   <= '{default: '0};
            tgt_arr_q  <= '{default: '0};
            rr_q       <= '0;
            upd_pc_q   <= '0;
            upd_tgt_q  <= '0;
            upd_kind_q <= 1'b0;
            hit_q      <= 1'b0;
            idx_q      <= '0;
            evict_q    <= 1'b0;
            reject_q   <= 1'b0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            pc_arr_q   <= pc_arr_d;
            tgt_arr_q  <= tgt_arr_d;
            rr_q       <= rr_d;
            upd_pc_q   <= upd_pc_d;
            upd_tgt_q  <= upd_tgt_d;
            upd_kind_q <= upd_kind_d;
            hit_q      <= hit_d;
            idx_q      <= idx_d;
            evict_q    <= evict_d;
            reject_q   <= reject_d;
            fill_q     <= fill_d;
        end
    end
endmodule

// File: tb/tb_branch_cache_writer.sv
// tb_branch_cache_writer: scoreboard bench with a behavioural table model
`timescale 1ns/1ps
module tb_branch_cache_writer;
    logic        Clk = 0;
    logic        Reset = 1;
    logic        iUpdValid = 0;
    logic        oUpdReady;
    logic [31:0] iUpdPC = 0, iUpdTarget = 0, iLookupPC = 0;
    logic        iUpdKind = 0;
    logic [31:0] oCacheAddress;
    logic        ocCache, oEvict, oReject;
    logic [3:0]  oFillCount;

    branch_cache_writer dut (
        .Clk(Clk), .Reset(Reset), .iUpdValid(iUpdValid), .oUpdReady(oUpdReady),
        .iUpdPC(iUpdPC), .iUpdTarget(iUpdTarget), .iUpdKind(iUpdKind),
        .iLookupPC(iLookupPC), .oCacheAddress(oCacheAddress), .ocCache(ocCache),
        .oEvict(oEvict), .oReject(oReject), .oFillCount(oFillCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          rej;
        bit          evict;
        int          old_fill;
        int          new_fill;
        bit          old_hit;
        logic [31:0] old_addr;
        bit          new_hit;
        logic [31:0] new_addr;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   quiet = 0;

    // reference model: a plain list of (valid, pc, target) slots plus a replacement pointer
    bit          mv[8];
    logic [31:0] mp[8], mt[8];
    int          mrr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mfill();
        int n = 0;
        foreach (mv[i]) n += mv[i];
        return n;
    endfunction

    function automatic void mlook(input logic [31:0] pc, output bit h, output logic [31:0] a);
        h = 0; a = 0;
        for (int i = 0; i < 8; i++) if (!h && mv[i] && mp[i] == pc) begin h = 1; a = mt[i]; end
    endfunction

    function automatic void mreset();
        foreach (mv[i]) begin mv[i] = 0; mp[i] = 0; mt[i] = 0; end
        mrr = 0;
    endfunction

    // apply one update to the model; returns reject/evict outcome
    function automatic void mapply(input logic [31:0] pc, input logic [31:0] tgt, input bit kind,
                                   output bit rej, output bit ev);
        int hit = -1, free = -1;
        rej = 0; ev = 0;
        if (pc[1:0] != 0 || (kind && tgt[1:0] != 0)) begin rej = 1; return; end
        for (int i = 7; i >= 0; i--) begin
            if (mv[i] && mp[i] == pc) hit = i;
            if (!mv[i]) free = i;
        end
        if (kind) begin
            if (hit >= 0) mt[hit] = tgt;
            else begin
                if (free < 0) begin free = mrr; ev = 1; mrr = (mrr + 1) % 8; end
                mv[free] = 1; mp[free] = pc; mt[free] = tgt;
            end
        end else if (hit >= 0) mv[hit] = 0;
    endfunction

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge Clk); n++; end while (!(oUpdReady && q.size() == 0) && n < 50);
        if (!(oUpdReady && q.size() == 0)) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] tgt, input bit kind, input logic [31:0] lk);
        exp_t e;
        wait_idle();
        #2;
        iUpdPC = pc; iUpdTarget = tgt; iUpdKind = kind; iLookupPC = lk; iUpdValid = 1;
        e.old_fill = mfill();
        mlook(lk, e.old_hit, e.old_addr);
        mapply(pc, tgt, kind, e.rej, e.evict);
        e.new_fill = mfill();
        mlook(lk, e.new_hit, e.new_addr);
        q.push_back(e);
        @(posedge Clk);
        #1 iUpdValid = 0;
    endtask

    // monitor: checks the old view while busy and pops an expectation on completion or reject
    initial begin
        bit prev_ready = 1;
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!quiet && !Reset) begin
                if (oReject || (oUpdReady && !prev_ready)) begin
                    if (q.size() == 0) chk("spurious_event", 32'd1, 32'd0);
                    else begin
                        e = q.pop_front();
                        chk("reject", 32'(oReject), 32'(e.rej));
                        chk("evict", 32'(oEvict), 32'(e.evict));
                        chk("fill", 32'(oFillCount), 32'(e.new_fill));
                        chk("hit", 32'(ocCache), 32'(e.new_hit));
                        chk("addr", oCacheAddress, e.new_addr);
                        if (e.rej) chk("ready_on_reject", 32'(oUpdReady), 32'd1);
                    end
                end else if (!oUpdReady && q.size() > 0) begin
                    e = q[0];
                    chk("busy_hit", 32'(ocCache), 32'(e.old_hit));
                    chk("busy_addr", oCacheAddress, e.old_addr);
                    chk("busy_fill", 32'(oFillCount), 32'(e.old_fill));
                    chk("busy_evict", 32'(oEvict), 32'd0);
                end
            end
            prev_ready = oUpdReady;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc, tgt;
        mreset();
        iLookupPC = 32'h14;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_hit", 32'(ocCache), 32'd0);
        chk("rst_addr", oCacheAddress, 32'd0);
        chk("rst_fill", 32'(oFillCount), 32'd0);
        chk("rst_ready", 32'(oUpdReady), 32'd1);
        @(negedge Clk);
        Reset = 0;
        issue(32'h14, 32'h10, 1, 32'h14);
        issue(32'h14, 32'h40, 1, 32'h14);
        issue(32'h14, 32'h0, 0, 32'h14);
        for (int i = 0; i < 9; i++) issue(32'h100 + 32'(4 * i), 32'h1000 + 32'(i * 16), 1, 32'h100 + 32'(4 * i));
        issue(32'h0, 32'h0, 1, 32'h100);
        issue(32'h0, 32'h0, 1, 32'h120);
        issue(32'h124, 32'h2000, 1, 32'h104);
        issue(32'h108, 32'h0, 0, 32'h108);
        issue(32'h200, 32'h0, 0, 32'h10C);
        issue(32'h15, 32'h40, 1, 32'h10C);
        issue(32'h18, 32'h42, 1, 32'h18);
        for (int n = 0; n < 300; n++) begin
            pc  = 32'h400 + 32'($urandom_range(0, 15) * 4);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            issue(pc, tgt, $urandom_range(0, 3) != 0, 32'h400 + 32'($urandom_range(0, 15) * 4));
        end
        wait_idle();
        quiet = 1;
        #2;
        iUpdPC = 32'h300; iUpdTarget = 32'h3000; iUpdKind = 1; iLookupPC = 32'h300; iUpdValid = 1;
        @(posedge Clk);
        #1 iUpdValid = 0;
        @(posedge Clk);
        #2 Reset = 1;
        #1;
        mreset();
        chk("mid_rst_hit", 32'(ocCache), 32'd0);
        chk("mid_rst_fill", 32'(oFillCount), 32'd0);
        chk("mid_rst_ready", 32'(oUpdReady), 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 0;
        chk("post_rst_hit", 32'(ocCache), 32'd0);
        quiet = 0;
        issue(32'h304, 32'h3040, 1, 32'h304);
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
